// File: rtl/tex_dcr_bank_pkg.sv
// Texture DCR types shared by the DCR bank and the sampler pipeline.
// This file holds the per-stage state struct and the DCR window offsets.
package tex_types;

  localparam int TEX_ADDR_BITS   = 32;
  localparam int TEX_FORMAT_BITS = 3;
  localparam int TEX_FILTER_BITS = 2;
  localparam int TEX_WRAP_BITS   = 2;
  localparam int TEX_LOD_BITS    = 4;
  localparam int TEX_LOD_MAX     = 7;
  localparam int TEX_MIPOFF_BITS = 25;

  typedef struct packed {
    logic [TEX_ADDR_BITS-1:0]                    baddr;
    logic [TEX_LOD_MAX:0][TEX_MIPOFF_BITS-1:0]   mipoff;
    logic [1:0][TEX_LOD_BITS-1:0]                logdims;
    logic [1:0][TEX_WRAP_BITS-1:0]               wraps;
    logic [TEX_FORMAT_BITS-1:0]                  format;
    logic [TEX_FILTER_BITS-1:0]                  filter;
  } tex_dcrs_t;

  // Offsets relative to the base of the texture DCR window.
  localparam int TEX_DCR_STAGE   = 0;
  localparam int TEX_DCR_ADDR    = 1;
  localparam int TEX_DCR_FORMAT  = 2;
  localparam int TEX_DCR_FILTER  = 3;
  localparam int TEX_DCR_WRAPS   = 4;
  localparam int TEX_DCR_LOGDIMS = 5;
  localparam int TEX_DCR_MIPOFF  = 6;
  localparam int TEX_DCR_NUM     = TEX_DCR_MIPOFF + TEX_LOD_MAX + 1;

  function automatic int stage_bits(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/tex_dcr_bank_if.sv
// DCR write bus plus stage-read request/response handshake of the texture DCR bank.
interface tex_dcr_bank_if
  import tex_types::*;
#(
    parameter int NUM_STAGES    = 2,
    parameter int DCR_ADDR_BITS = 12
);
    localparam int SW = stage_bits(NUM_STAGES);

    logic                     dcr_wr_valid;
    logic [DCR_ADDR_BITS-1:0] dcr_wr_addr;
    logic [31:0]              dcr_wr_data;
    logic                     dcr_wr_err;

    logic                     req_valid;
    logic                     req_ready;
    logic [SW-1:0]            req_stage;

    logic                     rsp_valid;
    logic                     rsp_ready;
    tex_dcrs_t                rsp_dcrs;

    modport master (
        output dcr_wr_valid, dcr_wr_addr, dcr_wr_data,
        input  dcr_wr_err,
        output req_valid, req_stage,
        input  req_ready,
        input  rsp_valid, rsp_dcrs,
        output rsp_ready
    );

    modport slave (
        input  dcr_wr_valid, dcr_wr_addr, dcr_wr_data,
        output dcr_wr_err,
        input  req_valid, req_stage,
        output req_ready,
        output rsp_valid, rsp_dcrs,
        input  rsp_ready
    );

endinterface

// File: rtl/tex_dcr_bank_pipe_reg.sv
// One-entry elastic pipe register with a reset-able data path.
module tex_dcr_bank_pipe_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_data,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_data
);

    // A held entry frees its slot in the same cycle it is consumed.
    assign enq_ready = !deq_valid || deq_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deq_valid <= 1'b0;
            deq_data  <= '0;
        end else if (enq_valid && enq_ready) begin
            deq_valid <= 1'b1;
            deq_data  <= enq_data;
        end else if (deq_ready) begin
            deq_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/tex_dcr_bank.sv
// Decodes DCR writes into per-stage texture state and serves registered
// snapshot reads of one stage to the texture unit.
module tex_dcr_bank
  import tex_types::*;
#(
    parameter int                       NUM_STAGES    = 2,
    parameter int                       DCR_ADDR_BITS = 12,
    parameter logic [DCR_ADDR_BITS-1:0] DCR_BASE      = 'h100
) (
    input  logic           clk,
    input  logic           reset,
    tex_dcr_bank_if.slave  bus
);

    localparam int SW = stage_bits(NUM_STAGES);

    tex_dcrs_t                stages [NUM_STAGES];
    logic [SW-1:0]            stage_sel;
    logic [DCR_ADDR_BITS-1:0] wr_off;
    int                       wr_idx;
    logic                     sel_wr;
    logic                     sel_bad;
    tex_dcrs_t                rd_dcrs;

    // Addresses below the base wrap to large offsets and fall outside the map.
    assign wr_off  = bus.dcr_wr_addr - DCR_BASE;
    assign wr_idx  = int'(wr_off);
    assign sel_wr  = bus.dcr_wr_valid && (wr_idx == TEX_DCR_STAGE);
    assign sel_bad = bus.dcr_wr_data >= 32'(NUM_STAGES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_sel      <= '0;
            bus.dcr_wr_err <= 1'b0;
        end else begin
            bus.dcr_wr_err <= sel_wr && sel_bad;
            if (sel_wr && !sel_bad) begin
                stage_sel <= bus.dcr_wr_data[SW-1:0];
            end
        end
    end

    // NOTE: this state array is reset on purpose; readers may legally fetch any stage before software programs it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                stages[s] <= '0;
            end
        end else if (bus.dcr_wr_valid) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (int'(stage_sel) == s) begin
                    case (wr_idx)
                        TEX_DCR_ADDR:    stages[s].baddr  <= bus.dcr_wr_data[TEX_ADDR_BITS-1:0];
                        TEX_DCR_FORMAT:  stages[s].format <= bus.dcr_wr_data[TEX_FORMAT_BITS-1:0];
                        TEX_DCR_FILTER:  stages[s].filter <= bus.dcr_wr_data[TEX_FILTER_BITS-1:0];
                        TEX_DCR_WRAPS: begin
                            stages[s].wraps[0] <= bus.dcr_wr_data[TEX_WRAP_BITS-1:0];
                            stages[s].wraps[1] <= bus.dcr_wr_data[16 +: TEX_WRAP_BITS];
                        end
                        TEX_DCR_LOGDIMS: begin
                            stages[s].logdims[0] <= bus.dcr_wr_data[TEX_LOD_BITS-1:0];
                            stages[s].logdims[1] <= bus.dcr_wr_data[16 +: TEX_LOD_BITS];
                        end
                        default: ;
                    endcase
                    for (int l = 0; l <= TEX_LOD_MAX; l++) begin
                        if (wr_idx == TEX_DCR_MIPOFF + l) begin
                            stages[s].mipoff[l] <= bus.dcr_wr_data[TEX_MIPOFF_BITS-1:0];
                        end
                    end
                end
            end
        end
    end

    // The read sees the pre-edge copy, so a same-cycle write is not visible yet.
    always_comb begin
        // NOTE: the default assignment first keeps this combinational block from inferring a latch.
        rd_dcrs = '0;
        if (int'(bus.req_stage) < NUM_STAGES) begin
            rd_dcrs = stages[bus.req_stage];
        end
    end

    tex_dcr_bank_pipe_reg #(
        .WIDTH($bits(tex_dcrs_t))
    ) u_rsp_reg (
        .clk       (clk),
        .reset     (reset),
        .enq_valid (bus.req_valid),
        .enq_ready (bus.req_ready),
        .enq_data  (rd_dcrs),
        .deq_valid (bus.rsp_valid),
        .deq_ready (bus.rsp_ready),
        .deq_data  (bus.rsp_dcrs)
    );

endmodule

// File: tb/tb_tex_dcr_bank.sv
// Directed self-checking bench for tex_dcr_bank.
module tb_tex_dcr_bank;
    import tex_types::*;

    localparam int          NUM_STAGES    = 2;
    localparam int          DCR_ADDR_BITS = 12;
    localparam logic [11:0] DCR_BASE      = 12'h100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tex_dcr_bank_if #(.NUM_STAGES(NUM_STAGES), .DCR_ADDR_BITS(DCR_ADDR_BITS)) bus ();

    tex_dcr_bank #(
        .NUM_STAGES    (NUM_STAGES),
        .DCR_ADDR_BITS (DCR_ADDR_BITS),
        .DCR_BASE      (DCR_BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    tex_dcrs_t exp1;
    tex_dcrs_t held;
    tex_dcrs_t got;
    int        rsp_count;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dcr_write_raw(input logic [11:0] addr, input logic [31:0] data);
        bus.dcr_wr_valid = 1'b1;
        bus.dcr_wr_addr  = addr;
        bus.dcr_wr_data  = data;
        tick();
        bus.dcr_wr_valid = 1'b0;
    endtask

    task automatic dcr_write(input int off, input logic [31:0] data);
        dcr_write_raw(DCR_BASE + 12'(off), data);
    endtask

    // Issue one request, expect the response one cycle later, then consume it.
    task automatic read_stage(input logic [0:0] stage, output tex_dcrs_t dcrs);
        bus.req_valid = 1'b1;
        bus.req_stage = stage;
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check("rd_valid", bus.rsp_valid, 1);
        dcrs = bus.rsp_dcrs;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        bus.dcr_wr_valid = 1'b0;
        bus.dcr_wr_addr  = '0;
        bus.dcr_wr_data  = '0;
        bus.req_valid    = 1'b0;
        bus.req_stage    = '0;
        bus.rsp_ready    = 1'b0;
        #12;
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_dcrs", bus.rsp_dcrs, 0);
        check("rst_wr_err", bus.dcr_wr_err, 0);
        check("rst_req_ready", bus.req_ready, 1);
        tick();
        reset = 1'b0;
        tick();

        // 1: stage 0 reads back zero after reset
        read_stage(1'b0, got);
        check("t1_dcrs", got, 0);
        check("t1_wr_err", bus.dcr_wr_err, 0);

        // 2: program stage 1, including boundary offsets and excess data bits
        dcr_write(TEX_DCR_STAGE, 32'd1);
        check("t2_sel_err", bus.dcr_wr_err, 0);
        dcr_write(TEX_DCR_ADDR, 32'h000A_BCDE);
        dcr_write(TEX_DCR_WRAPS, 32'h0002_0001);
        dcr_write(TEX_DCR_MIPOFF, 32'h0000_0040);
        dcr_write(TEX_DCR_LOGDIMS, 32'hFFF3_FFF5);
        dcr_write(TEX_DCR_MIPOFF + TEX_LOD_MAX, 32'hFFFF_FFFF);
        dcr_write(TEX_DCR_NUM, 32'hFFFF_FFFF);
        dcr_write_raw(DCR_BASE - 12'd1, 32'h0000_0000);
        check("t2_oob_err", bus.dcr_wr_err, 0);
        exp1            = '0;
        exp1.baddr      = 32'h000A_BCDE;
        exp1.wraps[0]   = 2'd1;
        exp1.wraps[1]   = 2'd2;
        exp1.mipoff[0]  = 25'h40;
        exp1.logdims[0] = 4'd5;
        exp1.logdims[1] = 4'd3;
        exp1.mipoff[7]  = 25'h1FF_FFFF;
        read_stage(1'b1, got);
        check("t2_baddr", got.baddr, 32'h000A_BCDE);
        check("t2_wraps0", got.wraps[0], 1);
        check("t2_wraps1", got.wraps[1], 2);
        check("t2_mipoff0", got.mipoff[0], 32'h40);
        check("t2_logdims0", got.logdims[0], 5);
        check("t2_logdims1", got.logdims[1], 3);
        check("t2_mipoff7", got.mipoff[7], 32'h1FF_FFFF);
        check("t2_stage1", got, exp1);
        read_stage(1'b0, got);
        check("t2_stage0", got, 0);

        // 3: illegal stage selects pulse the error and leave the selection alone
        dcr_write(TEX_DCR_STAGE, 32'd2);
        check("t3_err_hi", bus.dcr_wr_err, 1);
        dcr_write(TEX_DCR_STAGE, 32'h0001_0000);
        check("t3_err_wide", bus.dcr_wr_err, 1);
        dcr_write(TEX_DCR_FORMAT, 32'd3);
        check("t3_err_lo", bus.dcr_wr_err, 0);
        tick();
        check("t3_err_idle", bus.dcr_wr_err, 0);
        exp1.format = 3'd3;
        read_stage(1'b1, got);
        check("t3_stage1", got, exp1);
        read_stage(1'b0, got);
        check("t3_stage0", got, 0);

        // 4: same-cycle write and read returns the pre-write value
        dcr_write(TEX_DCR_FORMAT, 32'd2);
        bus.dcr_wr_valid = 1'b1;
        bus.dcr_wr_addr  = DCR_BASE + 12'(TEX_DCR_FORMAT);
        bus.dcr_wr_data  = 32'd5;
        bus.req_valid    = 1'b1;
        bus.req_stage    = 1'b1;
        bus.rsp_ready    = 1'b1;
        tick();
        bus.dcr_wr_valid = 1'b0;
        bus.req_valid    = 1'b0;
        check("t4_valid", bus.rsp_valid, 1);
        check("t4_old_fmt", bus.rsp_dcrs.format, 2);
        tick();
        read_stage(1'b1, got);
        check("t4_new_fmt", got.format, 5);
        exp1.format = 3'd5;

        // 5: stalled response stays frozen across writes, then full throughput
        bus.req_valid = 1'b1;
        bus.req_stage = 1'b1;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_stage = 1'b0;
        check("t5_valid", bus.rsp_valid, 1);
        check("t5_first", bus.rsp_dcrs, exp1);
        held = exp1;
        for (int i = 0; i < 4; i++) begin
            dcr_write(TEX_DCR_FILTER, (i == 3) ? 32'hFFFF_FFFD : 32'(i + 1));
            check("t5_hold_dcrs", bus.rsp_dcrs, held);
            check("t5_hold_valid", bus.rsp_valid, 1);
            check("t5_req_ready", bus.req_ready, 0);
        end
        exp1.filter = 2'd1;
        bus.rsp_ready = 1'b1;
        rsp_count = 0;
        for (int k = 0; k < 8; k++) begin
            bus.req_valid = 1'b1;
            bus.req_stage = 1'(k);
            tick();
            if (bus.rsp_valid) rsp_count++;
            check("t5_b2b_dcrs", bus.rsp_dcrs, (k % 2 == 1) ? exp1 : tex_dcrs_t'('0));
        end
        bus.req_valid = 1'b0;
        tick();
        check("t5_b2b_count", rsp_count, 8);
        check("t5_drain", bus.rsp_valid, 0);

        // 6: reset with a pending response clears everything at once
        bus.req_valid = 1'b1;
        bus.req_stage = 1'b1;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        check("t6_pending", bus.rsp_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_valid", bus.rsp_valid, 0);
        check("t6_rst_dcrs", bus.rsp_dcrs, 0);
        tick();
        reset = 1'b0;
        tick();
        read_stage(1'b0, got);
        check("t6_stage0", got, 0);
        read_stage(1'b1, got);
        check("t6_stage1", got, 0);
        dcr_write(TEX_DCR_ADDR, 32'h0000_1234);
        read_stage(1'b0, got);
        check("t6_sel_reset", got.baddr, 32'h0000_1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
